qpsk_frame_sched: RTL and testbench

Frame scheduler in front of qpsk_mod. It arbitrates round-robin between two 24-bit payload requesters, for example the hh:mm:ss time source and a message source. It wraps the granted payload into a 40-bit frame: header, three payload bytes, checksum. It holds each frame on qpsk_mod's para_in for a fixed number of clock cycles, one frame period, and optionally fills unused slots with idle frames.

---
 rtl/qpsk_pkg.sv | 19 +
 rtl/qpsk_frame_pack.sv | 18 +
 rtl/qpsk_frame_sched.sv | 119 +++++++++++
 tb/tb_qpsk_frame_sched.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK frame scheduler, frame packer and demod checker.
package qpsk_pkg;

    localparam int FRAME_W   = 40;
    localparam int PAYLOAD_W = 24;
    localparam int HDR_W     = 8;

    localparam logic [1:0] SRC_IDLE = 2'b00;
    localparam logic [1:0] SRC_A    = 2'b01;
    localparam logic [1:0] SRC_B    = 2'b10;

    localparam logic [HDR_W-1:0] DEFAULT_HEADER = 8'hcc;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } sched_state_t;

endpackage

// File: rtl/qpsk_frame_pack.sv
// Combinational frame builder: header, three payload bytes and an 8-bit modular checksum.
module qpsk_frame_pack
    import qpsk_pkg::*;
(
    input  logic [HDR_W-1:0]     header,
    input  logic [PAYLOAD_W-1:0] payload,
    output logic [FRAME_W-1:0]   frame
);

    logic [7:0] csum;

    // Checksum is the byte sum of the payload with the carry dropped
    always_comb begin
        csum  = payload[23:16] + payload[15:8] + payload[7:0];
        frame = {header, payload, csum};
    end

endmodule

// File: rtl/qpsk_frame_sched.sv
// Round-robin frame scheduler: picks a payload source, frames it and holds it for one frame period.
module qpsk_frame_sched
    import qpsk_pkg::*;
#(
    parameter logic [HDR_W-1:0]     HEADER       = DEFAULT_HEADER,
    parameter logic [15:0]          FRAME_CYCLES = 16'd20000,
    parameter logic                 IDLE_EN      = 1'b0,
    parameter logic [PAYLOAD_W-1:0] IDLE_PAYLOAD = 24'h000000
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_a,
    input  logic [PAYLOAD_W-1:0] dat_a,
    output logic                 ack_a,
    input  logic                 req_b,
    input  logic [PAYLOAD_W-1:0] dat_b,
    output logic                 ack_b,
    output logic [FRAME_W-1:0]   para_o,
    output logic                 frame_start,
    output logic                 busy,
    output logic [1:0]           src_o,
    output logic [15:0]          frame_cnt
);

    sched_state_t         state, state_nxt;
    logic [15:0]          hold_cnt, hold_nxt;
    logic [1:0]           rr_last, rr_nxt;
    logic [FRAME_W-1:0]   para_nxt;
    logic [1:0]           src_nxt;
    logic [15:0]          cnt_nxt;
    logic                 ack_a_nxt, ack_b_nxt, start_nxt;
    logic                 grant_a, grant_b;
    logic [PAYLOAD_W-1:0] sel_payload;
    logic [FRAME_W-1:0]   packed_frame;

    // Round-robin grant: on a tie the source that did not win last time goes first
    always_comb begin
        grant_a     = req_a && (!req_b || (rr_last == SRC_B));
        grant_b     = req_b && (!req_a || (rr_last == SRC_A));
        sel_payload = IDLE_PAYLOAD;
        if (grant_a) begin
            sel_payload = dat_a;
        end else if (grant_b) begin
            sel_payload = dat_b;
        end
    end

    qpsk_frame_pack u_pack (
        .header  (HEADER),
        .payload (sel_payload),
        .frame   (packed_frame)
    );

    // Next-state logic: load a new frame whenever the current period has expired or we are idle
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        rr_nxt    = rr_last;
        para_nxt  = para_o;
        src_nxt   = src_o;
        cnt_nxt   = frame_cnt;
        ack_a_nxt = 1'b0;
        ack_b_nxt = 1'b0;
        start_nxt = 1'b0;
        if ((state == ST_IDLE) || (hold_cnt == 16'd0)) begin
            if (grant_a || grant_b || IDLE_EN) begin
                state_nxt = ST_HOLD;
                hold_nxt  = FRAME_CYCLES - 16'd1;
                para_nxt  = packed_frame;
                start_nxt = 1'b1;
                cnt_nxt   = frame_cnt + 16'd1;
                if (grant_a) begin
                    ack_a_nxt = 1'b1;
                    src_nxt   = SRC_A;
                    rr_nxt    = SRC_A;
                end else if (grant_b) begin
                    ack_b_nxt = 1'b1;
                    src_nxt   = SRC_B;
                    rr_nxt    = SRC_B;
                end else begin
                    src_nxt   = SRC_IDLE;
                end
            end else begin
                state_nxt = ST_IDLE;
            end
        end else begin
            hold_nxt = hold_cnt - 16'd1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            hold_cnt    <= 16'd0;
            rr_last     <= SRC_B;
            para_o      <= {HEADER, 32'h0};
            src_o       <= SRC_IDLE;
            frame_cnt   <= 16'd0;
            ack_a       <= 1'b0;
            ack_b       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            rr_last     <= rr_nxt;
            para_o      <= para_nxt;
            src_o       <= src_nxt;
            frame_cnt   <= cnt_nxt;
            ack_a       <= ack_a_nxt;
            ack_b       <= ack_b_nxt;
            frame_start <= start_nxt;
        end
    end

    assign busy = (state == ST_HOLD);

endmodule

// File: tb/tb_qpsk_frame_sched.sv
// Directed bench for qpsk_frame_sched with a short frame period; dut1 runs with idle frames enabled.
module tb_qpsk_frame_sched;
    import qpsk_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_a, req_b;
    logic [23:0] dat_a, dat_b;

    logic        ack_a0, ack_b0, fs0, busy0;
    logic [39:0] para0;
    logic [1:0]  src0;
    logic [15:0] cnt0;

    logic        ack_a1, ack_b1, fs1, busy1;
    logic [39:0] para1;
    logic [1:0]  src1;
    logic [15:0] cnt1;

    int n_cmp = 0;
    int n_err = 0;

    qpsk_frame_sched #(
        .HEADER(8'hcc), .FRAME_CYCLES(16'd4), .IDLE_EN(1'b0), .IDLE_PAYLOAD(24'h000000)
    ) dut0 (
        .clk(clk), .rst(rst),
        .req_a(req_a), .dat_a(dat_a), .ack_a(ack_a0),
        .req_b(req_b), .dat_b(dat_b), .ack_b(ack_b0),
        .para_o(para0), .frame_start(fs0), .busy(busy0), .src_o(src0), .frame_cnt(cnt0)
    );

    qpsk_frame_sched #(
        .HEADER(8'hcc), .FRAME_CYCLES(16'd4), .IDLE_EN(1'b1), .IDLE_PAYLOAD(24'h000000)
    ) dut1 (
        .clk(clk), .rst(rst),
        .req_a(1'b0), .dat_a(24'h000000), .ack_a(ack_a1),
        .req_b(1'b0), .dat_b(24'h000000), .ack_b(ack_b1),
        .para_o(para1), .frame_start(fs1), .busy(busy1), .src_o(src1), .frame_cnt(cnt1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic ra, input logic [23:0] da,
                                 input logic rb, input logic [23:0] db);
        req_a = ra;
        dat_a = da;
        req_b = rb;
        dat_b = db;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string pfx);
        checkOutput({pfx, "_para"},  para0,  40'hcc00000000);
        checkOutput({pfx, "_busy"},  busy0,  1'b0);
        checkOutput({pfx, "_src"},   src0,   2'b00);
        checkOutput({pfx, "_cnt"},   cnt0,   16'd0);
        checkOutput({pfx, "_ack_a"}, ack_a0, 1'b0);
        checkOutput({pfx, "_ack_b"}, ack_b0, 1'b0);
        checkOutput({pfx, "_fs"},    fs0,    1'b0);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [39:0] exp_frame;
        logic [1:0]  exp_src;
        logic [15:0] c;
        logic        found;

        // 1. reset held for two edges
        applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
        rst = 1'b1;
        tick();
        tick();
        checkReset("rst1");
        rst = 1'b0;

        // 2. single request from A while idle
        applyStimulus(1'b1, 24'h123456, 1'b0, 24'h0);
        tick();
        checkOutput("t2_ack_a", ack_a0, 1'b1);
        checkOutput("t2_para",  para0,  40'hcc1234569c);
        checkOutput("t2_fs",    fs0,    1'b1);
        checkOutput("t2_src",   src0,   2'b01);
        checkOutput("t2_cnt",   cnt0,   16'd1);
        checkOutput("t2_busy1", busy0,  1'b1);
        applyStimulus(1'b0, 24'h123456, 1'b0, 24'h0);
        tick();
        checkOutput("t2_ack_a_drop", ack_a0, 1'b0);
        checkOutput("t2_fs_drop",    fs0,    1'b0);
        tick();
        tick();
        checkOutput("t2_busy4", busy0, 1'b1);
        tick();
        checkOutput("t2_busy_end", busy0, 1'b0);
        checkOutput("t2_para_kept", para0, 40'hcc1234569c);
        checkOutput("t2_src_kept",  src0,  2'b01);

        // 3. simultaneous requests after reset: A first, B one period later
        resetDut();
        checkReset("rst3");
        applyStimulus(1'b1, 24'h010203, 1'b1, 24'h0a0b0c);
        tick();
        checkOutput("t3_ack_a", ack_a0, 1'b1);
        checkOutput("t3_ack_b", ack_b0, 1'b0);
        checkOutput("t3_paraA", para0,  40'hcc01020306);
        checkOutput("t3_srcA",  src0,   2'b01);
        applyStimulus(1'b0, 24'h010203, 1'b1, 24'h0a0b0c);
        tick();
        tick();
        tick();
        checkOutput("t3_holdA", para0, 40'hcc01020306);
        checkOutput("t3_ack_b_wait", ack_b0, 1'b0);
        tick();
        checkOutput("t3_paraB", para0,  40'hcc0a0b0c21);
        checkOutput("t3_ack_bB", ack_b0, 1'b1);
        checkOutput("t3_srcB",  src0,   2'b10);
        checkOutput("t3_fsB",   fs0,    1'b1);
        checkOutput("t3_cnt",   cnt0,   16'd2);
        applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);

        // 4. both sources always requesting: strict alternation every period
        resetDut();
        applyStimulus(1'b1, 24'haabbcc, 1'b1, 24'h112233);
        tick();
        for (int f = 0; f < 6; f++) begin
            exp_frame = (f % 2 == 0) ? 40'hccaabbcc31 : 40'hcc11223366;
            exp_src   = (f % 2 == 0) ? 2'b01 : 2'b10;
            checkOutput($sformatf("t4_src%0d", f),  src0,  exp_src);
            checkOutput($sformatf("t4_para%0d", f), para0, exp_frame);
            checkOutput($sformatf("t4_fs%0d", f),   fs0,   1'b1);
            checkOutput($sformatf("t4_acka%0d", f), ack_a0, (f % 2 == 0) ? 1'b1 : 1'b0);
            checkOutput($sformatf("t4_ackb%0d", f), ack_b0, (f % 2 == 0) ? 1'b0 : 1'b1);
            if (f < 5) begin
                tick();
                tick();
                tick();
                checkOutput($sformatf("t4_fs_gap%0d", f), fs0, 1'b0);
                tick();
            end
        end
        checkOutput("t4_cnt", cnt0, 16'd6);
        applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);

        // 5. idle frames on dut1 and frame counter wrap
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (fs1) found = 1'b1;
            else tick();
        end
        checkOutput("t5_idle_start", found, 1'b1);
        checkOutput("t5_para", para1,  40'hcc00000000);
        checkOutput("t5_src",  src1,   2'b00);
        checkOutput("t5_acka", ack_a1, 1'b0);
        checkOutput("t5_ackb", ack_b1, 1'b0);
        c = cnt1 + 16'd1;
        tick();
        tick();
        tick();
        checkOutput("t5_fs_gap", fs1, 1'b0);
        tick();
        checkOutput("t5_fs_next", fs1,  1'b1);
        checkOutput("t5_cnt_inc", cnt1, c);
        tick();
        force dut1.frame_cnt = 16'hffff;
        tick();
        release dut1.frame_cnt;
        tick();
        checkOutput("t5_cnt_max",  cnt1, 16'hffff);
        tick();
        checkOutput("t5_cnt_wrap", cnt1, 16'h0000);
        checkOutput("t5_fs_wrap",  fs1,  1'b1);
        checkOutput("t5_para2",    para1, 40'hcc00000000);

        // 6. reset in the middle of a frame with B pending
        tick();
        tick();
        tick();
        checkOutput("t6_idle_before", busy0, 1'b0);
        applyStimulus(1'b1, 24'h445566, 1'b0, 24'h0);
        tick();
        checkOutput("t6_ack_a", ack_a0, 1'b1);
        applyStimulus(1'b0, 24'h445566, 1'b1, 24'h0c0d0e);
        tick();
        checkOutput("t6_ack_b_held", ack_b0, 1'b0);
        rst = 1'b1;
        tick();
        checkReset("rst6");
        rst = 1'b0;
        tick();
        checkOutput("t6_paraB", para0,  40'hcc0c0d0e27);
        checkOutput("t6_ack_b", ack_b0, 1'b1);
        checkOutput("t6_srcB",  src0,   2'b10);
        checkOutput("t6_cnt",   cnt0,   16'd1);
        applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
